reset_sequencer: RTL

Consumes the single global reset produced upstream and turns it into an ordered, glitch-free set of staged reset releases for the rest of the FPGA. Assertion is immediate and asynchronous; release is synchronized to `i_clk`, held for a minimum time, then applied to each stage in turn, with a fixed gap between stages. A software hold request re-enters reset without a full global reset. `o_ready` tells downstream logic that every stage is out of reset.

---
 rtl/rst_pkg.sv | 26 ++
 rtl/rst_sync.sv | 20 ++
 rtl/reset_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// counter sizing and elaboration-time parameter range checking.
package rst_pkg;

  localparam int RST_STATE_W = 2;

  typedef enum logic [RST_STATE_W-1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_READY   = 2'd3
  } rst_state_e;

  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int m;
    m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int n_stages, input int sync_stages,
                                   input int hold_cycles, input int stage_gap);
    return (n_stages >= 1) && (n_stages <= 8) && (sync_stages >= 2) &&
           (hold_cycles >= 1) && (stage_gap >= 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset release synchronizer: asserts asynchronously with i_rst and
// releases SYNC_STAGES clock edges after i_rst falls.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= '1;
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
  end

  assign o_rst_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: synchronized release of the global reset, a minimum
// hold time, then one stage released every STAGE_GAP edges, bit 0 first.
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rst_req,
  output logic [N_STAGES-1:0]    o_rst_stage,
  output logic                   o_ready,
  output logic [RST_STATE_W-1:0] o_state
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
  localparam rst_state_e AFTER_HOLD = (N_STAGES == 1) ? ST_READY : ST_RELEASE;

  if (!params_ok(N_STAGES, SYNC_STAGES, HOLD_CYCLES, STAGE_GAP)) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  logic                w_sync_rst;
  logic [CNT_W-1:0]    w_cnt_inc;
  rst_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [N_STAGES-1:0] r_stage;
  logic                r_ready;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_rst_sync (w_sync_rst)
  );

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stage <= '1;
      r_ready <= 1'b0;
    end else if (i_rst_req && (r_state != ST_ASSERT)) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stage <= '1;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (r_state == ST_READY);
      case (r_state)
        // The edge that leaves ST_ASSERT is counted as the first hold cycle,
        // so stage 0 releases SYNC_STAGES+HOLD_CYCLES edges after i_rst falls.
        ST_ASSERT: if (!w_sync_rst) begin
          if (HOLD_CYCLES == 1) begin
            r_stage[0] <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= IDX_W'(1);
            r_state    <= AFTER_HOLD;
          end else begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_cnt_inc == HOLD_T) begin
            r_stage[0] <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= IDX_W'(1);
            r_state    <= AFTER_HOLD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RELEASE: begin
          if (w_cnt_inc == GAP_T) begin
            r_stage[r_idx] <= 1'b0;
            r_cnt          <= '0;
            r_idx          <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) r_state <= ST_READY;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_READY: r_stage <= '0;
      endcase
    end
  end

  assign o_rst_stage = r_stage;
  assign o_ready     = r_ready;
  assign o_state     = r_state;

endmodule
